// File: rtl/b16_mem8_bridge_if.sv
// rtl/b16_mem8_bridge_if.sv - CPU-side and SRAM-side bus bundle of the b16 16-to-8 bit memory bridge
interface b16_mem8_bridge_if #(
    parameter int l = 16
);
    // CPU side
    logic [l-1:0] addr;
    logic         rd;
    logic [1:0]   wr;
    logic [l-1:0] cpu_dout;
    logic [l-1:0] cpu_din;
    logic         ready;
    // async SRAM side
    logic [l-1:0] mem_addr;
    logic [7:0]   mem_dout;
    logic [7:0]   mem_din;
    logic         mem_cs_n;
    logic         mem_oe_n;
    logic         mem_we_n;

    // the bridge itself
    modport slave (
        input  addr, rd, wr, cpu_dout, mem_din,
        output cpu_din, ready, mem_addr, mem_dout, mem_cs_n, mem_oe_n, mem_we_n
    );

    // the core plus the SRAM around the bridge
    modport master (
        output addr, rd, wr, cpu_dout, mem_din,
        input  cpu_din, ready, mem_addr, mem_dout, mem_cs_n, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/b16_mem8_bridge.sv
// rtl/b16_mem8_bridge.sv - b16 16-bit CPU access to 8-bit async SRAM bridge; optional last-word read buffer under B16_BRIDGE_LASTWORD_EN
module b16_mem8_bridge #(
    parameter int l    = 16,
    parameter int WAIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    b16_mem8_bridge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR_HI, WR_LO, DONE} state_t;

    localparam logic [3:0] WAIT_C = 4'(WAIT);

    state_t       state_q;
    logic [3:0]   cnt_q;
    logic [l-2:0] word_q;
    logic [1:0]   wr_q;
    logic [l-1:0] data_q;
    logic         gap_q;
    logic [l-1:0] cpu_din_q;
    logic [l-1:0] mem_addr_q;
    logic [7:0]   mem_dout_q;
    logic         cs_n_q;
    logic         oe_n_q;
    logic         we_n_q;

    logic         req;
    logic         phase_end;
    logic         hit;
    logic [l-1:0] hit_data;

    assign req       = bus.rd | (|bus.wr);
    assign phase_end = (cnt_q == WAIT_C);

`ifdef B16_BRIDGE_LASTWORD_EN
    logic         lw_valid_q;
    logic [l-2:0] lw_addr_q;
    logic [l-1:0] lw_data_q;

    assign hit      = lw_valid_q && bus.rd && !(|bus.wr) && (lw_addr_q == bus.addr[l-1:1]);
    assign hit_data = lw_data_q;

    // last-word buffer: filled as a word read completes, dropped by a write to that word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lw_valid_q <= 1'b0;
            lw_addr_q  <= '0;
            lw_data_q  <= '0;
        end else if (state_q == IDLE && (|bus.wr) && bus.addr[l-1:1] == lw_addr_q) begin
            lw_valid_q <= 1'b0;
        end else if (state_q == RD_LO && phase_end) begin
            lw_valid_q <= 1'b1;
            lw_addr_q  <= word_q;
            lw_data_q  <= {cpu_din_q[l-1:8], bus.mem_din};
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = cpu_din_q;
`endif

    // access sequencer: latches the request, walks the byte phases, drives registered strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            word_q     <= '0;
            wr_q       <= 2'b00;
            data_q     <= '0;
            gap_q      <= 1'b0;
            cpu_din_q  <= '0;
            mem_addr_q <= '0;
            mem_dout_q <= 8'h00;
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 4'd0;
                    gap_q <= 1'b0;
                    if (|bus.wr) begin
                        // a write wins over a simultaneous read
                        word_q <= bus.addr[l-1:1];
                        wr_q   <= bus.wr;
                        data_q <= bus.cpu_dout;
                        cs_n_q <= 1'b0;
                        oe_n_q <= 1'b1;
                        we_n_q <= 1'b0;
                        if (bus.wr[1]) begin
                            state_q    <= WR_HI;
                            mem_addr_q <= {bus.addr[l-1:1], 1'b0};
                            mem_dout_q <= bus.cpu_dout[l-1:8];
                        end else begin
                            state_q    <= WR_LO;
                            mem_addr_q <= {bus.addr[l-1:1], 1'b1};
                            mem_dout_q <= bus.cpu_dout[7:0];
                        end
                    end else if (hit) begin
                        cpu_din_q <= hit_data;
                    end else if (bus.rd) begin
                        word_q     <= bus.addr[l-1:1];
                        wr_q       <= 2'b00;
                        state_q    <= RD_HI;
                        mem_addr_q <= {bus.addr[l-1:1], 1'b0};
                        cs_n_q     <= 1'b0;
                        oe_n_q     <= 1'b0;
                        we_n_q     <= 1'b1;
                    end
                end
                RD_HI: begin
                    if (phase_end) begin
                        cpu_din_q[l-1:8] <= bus.mem_din;
                        cnt_q            <= 4'd0;
                        mem_addr_q       <= {word_q, 1'b1};
                        state_q          <= RD_LO;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RD_LO: begin
                    if (phase_end) begin
                        cpu_din_q[7:0] <= bus.mem_din;
                        cnt_q          <= 4'd0;
                        cs_n_q         <= 1'b1;
                        oe_n_q         <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                WR_HI: begin
                    if (phase_end) begin
                        cnt_q  <= 4'd0;
                        we_n_q <= 1'b1;
                        if (wr_q == 2'b11) begin
                            // odd byte follows after one we_n-high cycle with the new address/data
                            mem_addr_q <= {word_q, 1'b1};
                            mem_dout_q <= data_q[7:0];
                            gap_q      <= 1'b1;
                            state_q    <= WR_LO;
                        end else begin
                            cs_n_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                WR_LO: begin
                    if (gap_q) begin
                        gap_q  <= 1'b0;
                        we_n_q <= 1'b0;
                    end else if (phase_end) begin
                        cnt_q   <= 4'd0;
                        cs_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                end
            endcase
        end
    end

    // ready releases the core: idle with nothing asked, a buffer hit, or a finished access
    assign bus.ready    = reset & (((state_q == IDLE) && (!req || hit)) || (state_q == DONE));
    assign bus.cpu_din  = hit ? hit_data : cpu_din_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_cs_n = cs_n_q;
    assign bus.mem_oe_n = oe_n_q;
    assign bus.mem_we_n = we_n_q;
endmodule

// File: tb/tb_b16_mem8_bridge.sv
// tb/tb_b16_mem8_bridge.sv - self-checking bench for b16_mem8_bridge against a byte-array SRAM model
module tb_b16_mem8_bridge;
    localparam int W = 1;
`ifdef B16_BRIDGE_LASTWORD_EN
    localparam bit LW_EN = 1'b1;
`else
    localparam bit LW_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    b16_mem8_bridge_if #(.l(16)) bus ();

    b16_mem8_bridge #(.l(16), .WAIT(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] seed;
    logic [7:0]  sram    [0:65535];
    logic [7:0]  ref_mem [0:65535];
    bit          init_done = 1'b0;

    // reference state: last read data and last-word buffer occupancy
    logic [15:0] last_din;
    bit          lw_valid;
    logic [14:0] lw_word;
    bit          last_hit;

    int oe_cnt, we_cnt, cs_cnt, gap_cnt;

    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] h;
        h = 32'(i * 32'h9E3779B1) ^ seed;
        return h[20:13];
    endfunction

    // SRAM: combinational read, write while cs_n and we_n are low
    assign bus.mem_din = (!bus.mem_cs_n && !bus.mem_oe_n) ? sram[bus.mem_addr] : 8'hEE;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 65536; i++) sram[i] = init_byte(i);
            init_done = 1'b1;
        end else if (!bus.mem_cs_n && !bus.mem_we_n) begin
            sram[bus.mem_addr] = bus.mem_dout;
        end
    end

    // strobe activity per access, one sample per completed cycle
    always @(posedge clk) begin
        if (!bus.mem_oe_n) oe_cnt = oe_cnt + 1;
        if (!bus.mem_we_n) we_cnt = we_cnt + 1;
        if (!bus.mem_cs_n) cs_cnt = cs_cnt + 1;
        if (!bus.mem_cs_n && bus.mem_we_n && bus.mem_oe_n) gap_cnt = gap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rd = 1'b0;
        bus.wr = 2'b00;
        @(negedge clk);
    endtask

    // one CPU access; called at a falling edge, returns in the cycle ready is seen high
    task automatic access(input logic rd_i, input logic [1:0] wr_i, input logic [15:0] a,
                          input logic [15:0] d, input bit from_done);
        int          n;
        int          exp_lat;
        int          exp_oe, exp_we, exp_cs, exp_gap;
        logic [15:0] exp_din;
        logic [15:0] ev, od;
        bit          hit;
        ev = {a[15:1], 1'b0};
        od = {a[15:1], 1'b1};
        bus.rd       = rd_i;
        bus.wr       = wr_i;
        bus.addr     = a;
        bus.cpu_dout = d;
        if (from_done) @(negedge clk);
        oe_cnt = 0; we_cnt = 0; cs_cnt = 0; gap_cnt = 0;
        hit = LW_EN && rd_i && (wr_i == 2'b00) && lw_valid && (lw_word == a[15:1]);
        exp_oe = 0; exp_we = 0; exp_cs = 0; exp_gap = 0;
        if (wr_i != 2'b00) begin
            exp_din = last_din;
            if (wr_i == 2'b11) begin
                exp_lat = 2 * (W + 1) + 2;
                exp_we  = 2 * (W + 1);
                exp_cs  = 2 * (W + 1) + 1;
                exp_gap = 1;
            end else begin
                exp_lat = (W + 1) + 1;
                exp_we  = W + 1;
                exp_cs  = W + 1;
            end
        end else begin
            exp_din = {ref_mem[ev], ref_mem[od]};
            if (hit) begin
                exp_lat = 0;
            end else begin
                exp_lat = 2 * (W + 1) + 1;
                exp_oe  = 2 * (W + 1);
                exp_cs  = 2 * (W + 1);
            end
        end
        #1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("latency", n, exp_lat);
        chk("cpu_din", bus.cpu_din, exp_din);
        chk("oe_low_cycles", oe_cnt, exp_oe);
        chk("we_low_cycles", we_cnt, exp_we);
        chk("cs_low_cycles", cs_cnt, exp_cs);
        chk("we_gap_cycles", gap_cnt, exp_gap);
        if (hit) chk("hit_no_cs", bus.mem_cs_n, 1'b1);
        if (wr_i != 2'b00) begin
            if (wr_i[1]) ref_mem[ev] = d[15:8];
            if (wr_i[0]) ref_mem[od] = d[7:0];
            if (lw_word == a[15:1]) lw_valid = 1'b0;
        end else begin
            last_din = exp_din;
            lw_valid = 1'b1;
            lw_word  = a[15:1];
        end
        chk("sram_even", sram[ev], ref_mem[ev]);
        chk("sram_odd", sram[od], ref_mem[od]);
        last_hit = hit;
    endtask

    initial begin
        seed = $urandom;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        rst_n        = 1'b0;
        bus.rd       = 1'b0;
        bus.wr       = 2'b00;
        bus.addr     = 16'h0000;
        bus.cpu_dout = 16'h0000;
        last_din     = 16'h0000;
        lw_valid     = 1'b0;
        lw_word      = 15'h0;
        last_hit     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", bus.ready, 1'b0);
        chk("rst_cs_n", bus.mem_cs_n, 1'b1);
        chk("rst_oe_n", bus.mem_oe_n, 1'b1);
        chk("rst_we_n", bus.mem_we_n, 1'b1);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_dout", bus.mem_dout, 8'h00);
        chk("rst_cpu_din", bus.cpu_din, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", bus.ready, 1'b1);
        @(negedge clk);

        // word read of 0x0100 holding 12/34
        access(1'b0, 2'b11, 16'h0100, 16'h1234, 1'b0); idle();
        access(1'b1, 2'b00, 16'h0100, 16'h0000, 1'b0);
        chk("t1_word", bus.cpu_din, 16'h1234);
        idle();

        // even-lane byte write at an odd address
        access(1'b0, 2'b10, 16'h0203, 16'hAB55, 1'b0);
        chk("t2_even_byte", sram[16'h0202], 8'hAB);
        chk("t2_din_kept", bus.cpu_din, 16'h1234);
        idle();

        // full word write then read back
        access(1'b0, 2'b11, 16'h0300, 16'hBEEF, 1'b0); idle();
        access(1'b1, 2'b00, 16'h0300, 16'h0000, 1'b0);
        chk("t3_readback", bus.cpu_din, 16'hBEEF);
        idle();

        // back-to-back reads with the request held through DONE, then a repeat read
        access(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0);
        access(1'b1, 2'b00, 16'h0002, 16'h0000, 1'b1);
        idle();
        access(1'b1, 2'b00, 16'h0002, 16'h0000, 1'b0); idle();

        // odd-lane write invalidates the buffered word
        access(1'b0, 2'b11, 16'h0400, 16'h1111, 1'b0); idle();
        access(1'b1, 2'b00, 16'h0400, 16'h0000, 1'b0); idle();
        access(1'b0, 2'b01, 16'h0401, 16'h0022, 1'b0); idle();
        access(1'b1, 2'b00, 16'h0400, 16'h0000, 1'b0);
        chk("t5_reread", bus.cpu_din, 16'h1122);
        idle();

        // top of the address space stays inside word FFFE/FFFF
        access(1'b0, 2'b11, 16'hFFFF, 16'hC3A5, 1'b0); idle();
        access(1'b1, 2'b00, 16'hFFFF, 16'h0000, 1'b0);
        chk("wrap_word", bus.cpu_din, 16'hC3A5);
        chk("wrap_no_carry", sram[16'h0000], ref_mem[16'h0000]);
        idle();

        // random mix of reads and writes over a small window
        for (int k = 0; k < 40; k++) begin
            logic [15:0] a;
            logic [15:0] d;
            logic [1:0]  w;
            bit          b2b;
            a   = 16'h0600 | 16'($urandom_range(0, 15));
            d   = 16'($urandom);
            b2b = ($urandom_range(0, 1) == 1) && !last_hit;
            if (!b2b) idle();
            if ($urandom_range(0, 1) == 0) begin
                access(1'b1, 2'b00, a, 16'h0000, b2b);
            end else begin
                w = 2'($urandom_range(1, 3));
                access(1'b0, w, a, d, b2b);
            end
        end
        idle();

        // reset in the second cycle of WR_HI
        bus.rd       = 1'b0;
        bus.wr       = 2'b11;
        bus.addr     = 16'h0500;
        bus.cpu_dout = 16'h7788;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_we_n", bus.mem_we_n, 1'b1);
        chk("abort_cs_n", bus.mem_cs_n, 1'b1);
        chk("abort_ready", bus.ready, 1'b0);
        ref_mem[16'h0500] = 8'h77;
        last_din = 16'h0000;
        lw_valid = 1'b0;
        chk("abort_even", sram[16'h0500], ref_mem[16'h0500]);
        chk("abort_odd", sram[16'h0501], ref_mem[16'h0501]);
        bus.wr = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", bus.ready, 1'b1);
        @(negedge clk);
        access(1'b1, 2'b00, 16'h0500, 16'h0000, 1'b0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
